// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-outstanding instruction fetch FSM with ack timeout; optional FETCH_MISALIGN_TRAP_EN
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  output logic        oIMEM_REQ,
  output logic [31:0] oIMEM_ADDR,
  input  logic        iIMEM_ACK,
  input  logic [31:0] iIMEM_DATA,
  output logic [31:0] oIR,
  output logic [31:0] oPC,
  output logic        oIR_VALID,
  input  logic        iIR_READY,
  input  logic        iBR_TAKEN,
  input  logic [31:0] iPCBR,
  output logic        oFETCH_ERR,
  output logic        oMISALIGN
);

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [15:0] TIMEOUT_LIMIT    = 16'(ACK_TIMEOUT);
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] opc_q;
  logic [15:0] timeout_q;
  logic        req_q;
  logic        valid_q;
  logic        err_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_q;
`endif

  logic [31:0] pc_seq_d;
  logic [31:0] pc_redirect_d;
  logic [15:0] timeout_d;
  logic        redirect_bad_d;

  // Candidate next-pc values, timeout increment and the misaligned-redirect trap condition
  always_comb begin
    pc_seq_d      = pc_q + 32'd4;
    pc_redirect_d = iPCBR & 32'hFFFF_FFFC;
    timeout_d     = timeout_q + 16'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
    redirect_bad_d = iBR_TAKEN && (iPCBR[1:0] != 2'b00);
`else
    redirect_bad_d = 1'b0;
`endif
  end

  // Fetch FSM: all outputs are registered and change together with the state
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC_ALIGNED;
      ir_q       <= NOP;
      opc_q      <= RESET_PC;
      timeout_q  <= 16'd0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end
        S_REQ: begin
          if (iIMEM_ACK) begin
            ir_q      <= iIMEM_DATA;
            opc_q     <= pc_q;
            timeout_q <= 16'd0;
            req_q     <= 1'b0;
            valid_q   <= 1'b1;
            state_q   <= S_VALID;
          end else if (timeout_d == TIMEOUT_LIMIT) begin
            timeout_q <= timeout_d;
            req_q     <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            timeout_q <= timeout_d;
          end
        end
        S_VALID: begin
          if (iIR_READY) begin
            valid_q <= 1'b0;
            if (redirect_bad_d) begin
`ifdef FETCH_MISALIGN_TRAP_EN
              misalign_q <= 1'b1;
`endif
              state_q <= S_HALT;
            end else begin
              pc_q    <= iBR_TAKEN ? pc_redirect_d : pc_seq_d;
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_HALT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign oIMEM_REQ  = req_q;
  assign oIMEM_ADDR = pc_q;
  assign oIR        = ir_q;
  assign oPC        = opc_q;
  assign oIR_VALID  = valid_q;
  assign oFETCH_ERR = err_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign oMISALIGN  = misalign_q;
`else
  assign oMISALIGN  = 1'b0;
`endif

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter ACK_TIMEOUT, default 255, SHALL be the number of unacknowledged request cycles that is treated as a bus error (legal range 1..65535).
REQ-003 iCLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 iRST_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 oIMEM_REQ  output  1  SHALL be the instruction-memory read request.
REQ-006 oIMEM_ADDR  output  32  SHALL be the byte address of the requested word.
REQ-007 iIMEM_ACK  input  1  SHALL be the memory acknowledge; iIMEM_DATA is valid in the same cycle.
REQ-008 iIMEM_DATA  input  32  SHALL be the fetched instruction word.
REQ-009 oIR  output  32  SHALL be the instruction register fed to the decode/execute stage.
REQ-010 oPC  output  32  SHALL be the address oIR was fetched from.
REQ-011 oIR_VALID  output  1  SHALL flag that oIR/oPC hold an unconsumed instruction.
REQ-012 iIR_READY  input  1  SHALL flag that the consumer accepts oIR this cycle.
REQ-013 iBR_TAKEN  input  1  SHALL flag that the consumed instruction redirects the PC.
REQ-014 iPCBR  input  32  SHALL be the redirect target, meaningful only with iBR_TAKEN.
REQ-015 oFETCH_ERR  output  1  SHALL be the sticky acknowledge-timeout flag.
REQ-016 oMISALIGN  output  1  SHALL be the sticky misaligned-redirect flag.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, VALID, HALT.
REQ-018 IDLE: oIMEM_REQ=0; next state REQ unconditionally, i.e. exactly one IDLE cycle after reset release.
REQ-019 REQ: oIMEM_REQ=1, oIMEM_ADDR=pc; on iIMEM_ACK=1: latch oIR<=iIMEM_DATA, oPC<=pc, clear timeout counter, go to VALID.
REQ-020 REQ without ack SHALL increment a 16-bit timeout counter; when the counter equals ACK_TIMEOUT, the FSM SHALL set oFETCH_ERR=1 and go to HALT.
REQ-021 VALID: oIR_VALID=1, oIMEM_REQ=0; oIR/oPC held stable until iIR_READY=1.
REQ-022 VALID with iIR_READY=1: pc<=(iBR_TAKEN ? iPCBR : pc+4); go to REQ.
REQ-023 iBR_TAKEN/iPCBR SHALL be ignored in all states except VALID with iIR_READY=1.
REQ-024 iIMEM_ACK SHALL be ignored in IDLE, VALID and HALT.
REQ-025 HALT: oIMEM_REQ=0, oIR_VALID=0; the FSM SHALL remain in HALT until reset.
REQ-026 pc+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-027 Latency: ack in REQ cycle n -> oIR_VALID=1 in cycle n+1; best-case throughput is one instruction per 2 cycles.
REQ-028 oIMEM_ADDR SHALL equal pc in every state; bits [1:0] SHALL always be 0.

Reset
REQ-029 While iRST_N=0, regardless of iCLK: state=IDLE, pc=RESET_PC, oIR=32'h0000_0013 (NOP), oPC=RESET_PC, oIR_VALID=0, oIMEM_REQ=0, timeout=0, oFETCH_ERR=0, oMISALIGN=0.
REQ-030 Reset asserted mid-request or while oIR_VALID=1 SHALL abort the transaction immediately; a late ack after release SHALL be ignored (FSM is in IDLE).

Configuration
REQ-031 Macro FETCH_MISALIGN_TRAP_EN defined: an accepted redirect with iPCBR[1:0]!=0 SHALL set oMISALIGN=1 and enter HALT without updating pc.
REQ-032 Macro undefined: the redirect SHALL load pc<={iPCBR[31:2],2'b00}, and oMISALIGN SHALL be constant 0.

Verification
REQ-033 Reset release, memory acks every request at first REQ cycle with 32'h0000_0093 -> oIMEM_ADDR 0x0,0x4,0x8 on successive REQ cycles; oIR_VALID high every other cycle.
REQ-034 iIR_READY held 0 for 5 cycles in VALID -> oIR/oPC unchanged, oIMEM_REQ=0, no pc advance; READY=1 -> next REQ at pc+4.
REQ-035 VALID at oPC=0x10 with iIR_READY=1, iBR_TAKEN=1, iPCBR=0x200 -> next oIMEM_ADDR=0x200; iBR_TAKEN pulsed in REQ -> ignored.
REQ-036 ACK_TIMEOUT=4, ack never asserted -> oFETCH_ERR=1 after 4 REQ cycles, HALT, later acks ignored until reset.
REQ-037 pc=0xFFFF_FFFC consumed without branch -> next oIMEM_ADDR=0x0000_0000.
REQ-038 iPCBR=0x202 accepted: with FETCH_MISALIGN_TRAP_EN -> oMISALIGN=1, HALT; without -> oIMEM_ADDR=0x200, oMISALIGN=0.
